misr_signature_compactor: RTL



---
 rtl/misr_pkg.sv | 34 +++
 rtl/misr_reg.sv | 38 +++
 rtl/misr_signature_compactor.sv | 124 ++++++++++++
 3 files changed

// File: rtl/misr_pkg.sv
// Shared types and the MISR next-state function for the signature compactor.
//   state_e           : run-controller states
//   MISR_DEFAULT_POLY : x^14+x^5+x^3+x+1 taps (x^14 implicit)
//   misr_next()       : one Galois MISR step, usable for any width up to 63
package misr_pkg;

  localparam int unsigned MISR_MAX_W = 64;

  localparam logic [13:0] MISR_DEFAULT_POLY = 14'h002B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Galois step: shift left, fold the outgoing MSB back through the taps,
  // then XOR in the new vector. Result is masked to 'width' bits.
  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] data,
    input logic [MISR_MAX_W-1:0] poly,
    input int unsigned           width
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] shifted;
    logic                  msb;
    mask    = (MISR_MAX_W'(1) << width) - MISR_MAX_W'(1);
    msb     = sig[6'(width - 32'd1)];
    shifted = {sig[MISR_MAX_W-2:0], 1'b0};
    return (shifted ^ (msb ? poly : '0) ^ data) & mask;
  endfunction

endpackage

// File: rtl/misr_reg.sv
// WIDTH-bit signature register.
//   clk, reset  : clock, synchronous active-high reset (loads SEED)
//   load        : reload SEED (priority over enable)
//   enable      : absorb data into the signature this cycle
//   data        : vector to compact
//   sig         : registered signature
//   sig_next_c  : combinational value sig would take if enable were set
module misr_reg
  import misr_pkg::*;
#(
  parameter int unsigned      WIDTH = 14,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(MISR_DEFAULT_POLY),
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] sig_next_c
);

  assign sig_next_c = WIDTH'(misr_next(MISR_MAX_W'(sig), MISR_MAX_W'(data),
                                       MISR_MAX_W'(POLY), WIDTH));

  // Seed on reset/load, compact on enable, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (enable) begin
      sig <= sig_next_c;
    end
  end

endmodule

// File: rtl/misr_signature_compactor.sv
// MISR signature compactor with run controller: compacts TEST_COUNT valid
// CUT vectors after a start pulse, then stops and compares against GOLDEN.
//   clk, reset : clock, synchronous active-high reset
//   start      : begin/restart a run (priority over in_valid)
//   in_valid   : data_in carries a CUT vector this cycle
//   data_in    : CUT output vector
//   busy       : run in progress
//   done       : run finished, signature final
//   pass       : final signature matched GOLDEN (valid while done)
//   signature  : current MISR contents
//   count      : vectors compacted in this run
module misr_signature_compactor
  import misr_pkg::*;
#(
  parameter int unsigned      WIDTH      = 14,
  parameter int unsigned      TEST_COUNT = 148,
  parameter logic [WIDTH-1:0] POLY       = WIDTH'(MISR_DEFAULT_POLY),
  parameter logic [WIDTH-1:0] SEED       = '0,
  parameter logic [WIDTH-1:0] GOLDEN     = '0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                in_valid,
  input  logic [WIDTH-1:0]                    data_in,
  output logic                                busy,
  output logic                                done,
  output logic                                pass,
  output logic [WIDTH-1:0]                    signature,
  output logic [$clog2(TEST_COUNT+1)-1:0]     count
);

  localparam int unsigned CW = $clog2(TEST_COUNT + 1);

  state_e          state, state_d;
  logic [CW-1:0]   count_d;
  logic            pass_d;
  logic            load_c;
  logic            enable_c;
  logic            last_c;
  logic [WIDTH-1:0] sig_next_c;

  misr_reg #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (load_c),
    .enable     (enable_c),
    .data       (data_in),
    .sig        (signature),
    .sig_next_c (sig_next_c)
  );

  // Current sample is the final one of the run.
  assign last_c = (count == CW'(TEST_COUNT - 1));

  // Next-state, counter and compare logic.
  always_comb begin
    state_d  = state;
    count_d  = count;
    pass_d   = pass;
    load_c   = 1'b0;
    enable_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          load_c  = 1'b1;
          count_d = '0;
          pass_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (start) begin
          load_c  = 1'b1;
          count_d = '0;
          pass_d  = 1'b0;
        end else if (in_valid) begin
          enable_c = 1'b1;
          count_d  = count + CW'(1);
          if (last_c) begin
            state_d = ST_DONE;
            pass_d  = (sig_next_c == GOLDEN);
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          load_c  = 1'b1;
          count_d = '0;
          pass_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
        pass_d  = 1'b0;
      end
    endcase
  end

  // State, counter and flag registers; flags follow the next state so they
  // change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      pass  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      count <= count_d;
      pass  <= pass_d;
      busy  <= (state_d == ST_RUN);
      done  <= (state_d == ST_DONE);
    end
  end

endmodule
